// File: rtl/axis_cmd_pkg.sv
// Shared definitions for the ODIN command-stream arbiter.
//   - header opcode constants (upper nibble of the first byte of a command)
//   - cmd_len(): packet length in bytes decoded from a header byte, 0 = unknown
//   - arb_state_t: arbiter FSM states
package axis_cmd_pkg;

    localparam logic [3:0] HDR_CFG     = 4'b0001;
    localparam logic [3:0] HDR_AER     = 4'b0010;
    localparam logic [3:0] HDR_NEUR    = 4'b0100;
    localparam logic       HDR_SYN_MSB = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        FWD,
        DROP
    } arb_state_t;

    // The length includes the header byte itself.
    function automatic logic [2:0] cmd_len(input logic [7:0] hdr);
        logic [2:0] len;
        len = 3'd0;
        if (hdr[7] == HDR_SYN_MSB) begin
            len = 3'd4;
        end else begin
            case (hdr[7:4])
                HDR_NEUR: len = 3'd4;
                HDR_AER:  len = 3'd2;
                HDR_CFG:  len = 3'd1;
                default:  len = 3'd0;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter that owns the last-grant pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector, one bit per source
//   update     : commit the current grant as the new last-grant pointer
//   grant_idx  : index of the winning source, searching from last+1
// The pointer resets to N_SRC-1 so that source 0 wins the first arbitration.
module rr_arbiter #(
    parameter int unsigned N_SRC = 2,
    parameter int unsigned IDX_W = $clog2(N_SRC)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] req,
    input  logic             update,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] last;
    logic             found;
    int unsigned      idx;

    always_comb begin
        grant_idx = last;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 1; k <= N_SRC; k++) begin
            idx = (int'(last) + k) % N_SRC;
            if (!found && req[idx]) begin
                found     = 1'b1;
                grant_idx = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= IDX_W'(N_SRC - 1);
        end else if (update && found) begin
            last <= grant_idx;
        end
    end

endmodule

// File: rtl/axis_cmd_arbiter.sv
// Merges N_SRC host byte streams into the single 8-bit AXI-Stream command
// input of the ODIN command receiver, one complete packet per grant.
//   clk, rst_n     : clock, asynchronous active-low reset
//   s_axis_*       : source streams, source i byte at [8*i+7:8*i]
//   m_axis_*       : stream towards the command receiver
//   grant_idx      : current / last granted source
//   busy           : high in GRANT, FWD and DROP
//   pkt_cnt        : forwarded packets, saturating
//   drop_cnt       : dropped unknown headers, saturating
module axis_cmd_arbiter
    import axis_cmd_pkg::*;
#(
    parameter int unsigned N_SRC = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_SRC*8-1:0]       s_axis_tdata,
    input  logic [N_SRC-1:0]         s_axis_tvalid,
    output logic [N_SRC-1:0]         s_axis_tready,
    output logic [7:0]               m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(N_SRC)-1:0] grant_idx,
    output logic                     busy,
    output logic [CNT_W-1:0]         pkt_cnt,
    output logic [CNT_W-1:0]         drop_cnt
);

    localparam int unsigned IDX_W = $clog2(N_SRC);

    arb_state_t       state;
    logic [2:0]       remain;
    logic [7:0]       src_byte [N_SRC];
    logic [IDX_W-1:0] arb_idx;
    logic             arb_update;
    logic [2:0]       hdr_len;
    logic             in_fwd;
    logic             beat;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign src_byte[i] = s_axis_tdata[8*i +: 8];
    end

    assign arb_update = (state == IDLE) && (|s_axis_tvalid);

    rr_arbiter #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (s_axis_tvalid),
        .update    (arb_update),
        .grant_idx (arb_idx)
    );

    // Header is still held on the granted source in GRANT (valid may not drop).
    assign hdr_len = cmd_len(src_byte[grant_idx]);

    // Pure pass-through in FWD: valid depends only on state and source valid,
    // so there is no path from m_axis_tready to m_axis_tvalid.
    assign in_fwd        = (state == FWD);
    assign m_axis_tvalid = in_fwd && s_axis_tvalid[grant_idx];
    assign m_axis_tdata  = in_fwd ? src_byte[grant_idx] : '0;
    assign beat          = m_axis_tvalid && m_axis_tready;
    assign busy          = (state != IDLE);

    always_comb begin
        s_axis_tready = '0;
        if (state == FWD) begin
            s_axis_tready[grant_idx] = m_axis_tready;
        end else if (state == DROP) begin
            s_axis_tready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= '0;
            remain    <= '0;
            pkt_cnt   <= '0;
            drop_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|s_axis_tvalid) begin
                        grant_idx <= arb_idx;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (hdr_len != 3'd0) begin
                        remain <= hdr_len;
                        state  <= FWD;
                    end else begin
                        state <= DROP;
                    end
                end
                FWD: begin
                    if (beat) begin
                        remain <= remain - 3'd1;
                        if (remain == 3'd1) begin
                            if (pkt_cnt != '1) begin
                                pkt_cnt <= pkt_cnt + 1'b1;
                            end
                            state <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (drop_cnt != '1) begin
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_cmd_arbiter.sv
module tb_axis_cmd_arbiter;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [15:0]   s_tdata = '0;
    logic [1:0]    s_tvalid = '0;
    logic [1:0]    s_tready;
    logic [7:0]    m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic [0:0]    grant_idx;
    logic          busy;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] drop_cnt;

    always #5 clk = ~clk;

    axis_cmd_arbiter #(
        .N_SRC (2),
        .CNT_W (CW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .grant_idx     (grant_idx),
        .busy          (busy),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       src;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         vectors = 0;
    int         errors = 0;
    int         hs_cnt0 = 0;
    int         hs_cnt1 = 0;
    int         beat_cnt = 0;
    int         cyc = 0;
    int         beat_cyc[$];
    logic       toggle_rdy = 1'b0;
    logic       hs0 = 1'b0;
    logic       hs1 = 1'b0;

    // Source drivers and output monitor / scoreboard.
    initial begin
        exp_t       e;
        logic [7:0] tmp;
        forever begin
            @(negedge clk);
            cyc++;
            hs0 = s_tvalid[0] & s_tready[0];
            hs1 = s_tvalid[1] & s_tready[1];
            if (rst_n && m_tvalid) begin
                vectors++;
                if (s_tready[grant_idx] !== m_tready || s_tready[~grant_idx] !== 1'b0) begin
                    errors++;
                    $display("FAIL ready_mirror: s_tready=%b m_tready=%b grant=%0d", s_tready, m_tready, grant_idx);
                end
            end
            if (rst_n && m_tvalid && m_tready) begin
                beat_cnt++;
                beat_cyc.push_back(cyc);
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got data %h src %0d, expected nothing", m_tdata, grant_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (m_tdata !== e.data || grant_idx !== e.src) begin
                        errors++;
                        $display("FAIL beat: got data %h src %0d, expected data %h src %0d", m_tdata, grant_idx, e.data, e.src);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (hs0 && q0.size() > 0) begin tmp = q0.pop_front(); hs_cnt0++; end
            if (hs1 && q1.size() > 0) begin tmp = q1.pop_front(); hs_cnt1++; end
            s_tvalid[0]   = (q0.size() > 0);
            s_tdata[7:0]  = (q0.size() > 0) ? q0[0] : 8'h00;
            s_tvalid[1]   = (q1.size() > 0);
            s_tdata[15:8] = (q1.size() > 0) ? q1[0] : 8'h00;
            m_tready      = toggle_rdy ? ~m_tready : 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        exp_q.delete();
        beat_cyc.delete();
        toggle_rdy = 1'b0;
        hs_cnt0 = 0;
        hs_cnt1 = 0;
        beat_cnt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic push0(input logic [7:0] b, input logic fwd);
        q0.push_back(b);
        if (fwd) exp_q.push_back('{data: b, src: 1'b0});
    endtask

    task automatic push1(input logic [7:0] b, input logic fwd);
        q1.push_back(b);
        if (fwd) exp_q.push_back('{data: b, src: 1'b1});
    endtask

    task automatic wait_drain(input int max_cyc, input string name);
        int n = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < max_cyc) begin
            @(negedge clk);
            #1;
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d beats pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (s_tready !== 2'b00 || m_tvalid !== 1'b0 || m_tdata !== 8'h00 || busy !== 1'b0 ||
            pkt_cnt !== '0 || drop_cnt !== '0 || grant_idx !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b mv=%b md=%h busy=%b pkt=%0d drop=%0d g=%0d, expected all 0",
                     s_tready, m_tvalid, m_tdata, busy, pkt_cnt, drop_cnt, grant_idx);
        end
    endtask

    task automatic test_single();
        do_reset();
        push0(8'h81, 1); push0(8'h23, 1); push0(8'hFF, 1); push0(8'h5A, 1);
        wait_drain(50, "single");
        vectors++;
        if (beat_cyc.size() != 4 || beat_cyc[3] - beat_cyc[0] != 3) begin
            errors++;
            $display("FAIL single_consecutive: got %0d beats, expected 4 on consecutive cycles", beat_cyc.size());
        end
        vectors++;
        if (pkt_cnt !== 3'd1 || busy !== 1'b0 || drop_cnt !== 3'd0) begin
            errors++;
            $display("FAIL single_status: got pkt=%0d busy=%b drop=%0d, expected pkt=1 busy=0 drop=0", pkt_cnt, busy, drop_cnt);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        push0(8'h21, 1); push0(8'h0F, 1);
        push1(8'h22, 1); push1(8'hAA, 1);
        wait_drain(50, "simul");
        vectors++;
        if (pkt_cnt !== 3'd2 || grant_idx !== 1'b1 || hs_cnt0 != 2 || hs_cnt1 != 2) begin
            errors++;
            $display("FAIL simul_status: got pkt=%0d g=%0d hs0=%0d hs1=%0d, expected pkt=2 g=1 hs0=2 hs1=2",
                     pkt_cnt, grant_idx, hs_cnt0, hs_cnt1);
        end
    endtask

    task automatic test_drop();
        do_reset();
        push1(8'h70, 0); push1(8'h15, 1);
        wait_drain(50, "drop");
        vectors++;
        if (drop_cnt !== 3'd1 || pkt_cnt !== 3'd1 || hs_cnt1 != 2 || beat_cnt != 1) begin
            errors++;
            $display("FAIL drop_status: got drop=%0d pkt=%0d hs1=%0d beats=%0d, expected drop=1 pkt=1 hs1=2 beats=1",
                     drop_cnt, pkt_cnt, hs_cnt1, beat_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        toggle_rdy = 1'b1;
        push0(8'h40, 1); push0(8'h12, 1); push0(8'h0F, 1); push0(8'h33, 1);
        wait_drain(80, "bp");
        toggle_rdy = 1'b0;
        vectors++;
        if (beat_cnt != 4 || hs_cnt0 != 4 || pkt_cnt !== 3'd1) begin
            errors++;
            $display("FAIL bp_count: got beats=%0d hs0=%0d pkt=%0d, expected 4 4 1", beat_cnt, hs_cnt0, pkt_cnt);
        end
    endtask

    task automatic test_stall();
        int n = 0;
        do_reset();
        push0(8'h81, 1); push0(8'h01, 1);
        push1(8'h21, 0); push1(8'h55, 0);
        exp_q.push_back('{data: 8'h02, src: 1'b0});
        exp_q.push_back('{data: 8'h03, src: 1'b0});
        exp_q.push_back('{data: 8'h21, src: 1'b1});
        exp_q.push_back('{data: 8'h55, src: 1'b1});
        while (q0.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        vectors++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL stall_first_bytes: got %0d bytes left, expected 0", q0.size());
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vectors++;
            if (s_tready[1] !== 1'b0 || busy !== 1'b1 || grant_idx !== 1'b0 || m_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold: got rdy1=%b busy=%b g=%0d mv=%b, expected 0 1 0 0",
                         s_tready[1], busy, grant_idx, m_tvalid);
            end
        end
        #1;
        q0.push_back(8'h02);
        q0.push_back(8'h03);
        wait_drain(60, "stall");
        vectors++;
        if (pkt_cnt !== 3'd2 || hs_cnt1 != 2) begin
            errors++;
            $display("FAIL stall_status: got pkt=%0d hs1=%0d, expected 2 2", pkt_cnt, hs_cnt1);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        do_reset();
        push0(8'h40, 1); push0(8'h11, 1); push0(8'h22, 0); push0(8'h33, 0);
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #2;
        vectors++;
        if (m_tvalid !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: got mv=%b, expected 1", m_tvalid);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (s_tready !== 2'b00 || m_tvalid !== 1'b0 || m_tdata !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: got rdy=%b mv=%b md=%h busy=%b, expected all 0",
                     s_tready, m_tvalid, m_tdata, busy);
        end
        q0.delete();
        q1.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        vectors++;
        if (pkt_cnt !== 3'd0 || drop_cnt !== 3'd0 || grant_idx !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_counters: got pkt=%0d drop=%0d g=%0d, expected 0 0 0", pkt_cnt, drop_cnt, grant_idx);
        end
        push0(8'h10, 1);
        push1(8'h11, 1);
        wait_drain(50, "rstmid");
        vectors++;
        if (pkt_cnt !== 3'd2) begin
            errors++;
            $display("FAIL rstmid_pkt: got %0d, expected 2", pkt_cnt);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 9; i++) push0(8'h10 + 8'(i), 1);
        wait_drain(100, "sat_pkt");
        vectors++;
        if (pkt_cnt !== 3'd7) begin
            errors++;
            $display("FAIL sat_pkt: got %0d, expected 7", pkt_cnt);
        end
        for (int i = 0; i < 9; i++) push1(8'h30 + 8'(i), 0);
        wait_drain(100, "sat_drop");
        vectors++;
        if (drop_cnt !== 3'd7 || pkt_cnt !== 3'd7 || hs_cnt1 != 9) begin
            errors++;
            $display("FAIL sat_drop: got drop=%0d pkt=%0d hs1=%0d, expected 7 7 9", drop_cnt, pkt_cnt, hs_cnt1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_drop();
        test_backpressure();
        test_stall();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
